// File: rtl/hazard_forward_unit.sv
// Hazard detection and EX-operand forwarding control for a five-stage MIPS pipeline.
// Tracks in-flight destinations after ID, stalls on unresolvable RAW hazards, squashes ID on taken branches.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter bit FORWARD    = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_used,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            fwd_sel1,
    output logic [1:0]            fwd_sel2,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] dest;
    } entry_t;

    entry_t           ent [DEPTH];
    logic [DEPTH-1:0] m1, m2;
    logic             src1_chk, src2_chk;
    logic             hit1_mem, hit2_mem;
    logic             hazard, issue;
    logic [1:0]       sel1_nxt, sel2_nxt;

    assign src1_chk = id_valid && (id_src1 != '0);
    assign src2_chk = id_valid && id_src2_used && (id_src2 != '0);

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m1[k] = src1_chk && ent[k].valid && ent[k].wb_en && (ent[k].dest == id_src1);
            m2[k] = src2_chk && ent[k].valid && ent[k].wb_en && (ent[k].dest == id_src2);
        end
    end

    if (DEPTH > 1) begin : g_mem_stage
        assign hit1_mem = m1[1];
        assign hit2_mem = m2[1];
    end else begin : g_no_mem_stage
        assign hit1_mem = 1'b0;
        assign hit2_mem = 1'b0;
    end

    always_comb begin
        hazard = 1'b0;
        if (!FORWARD) begin
            hazard = |(m1 | m2);
        end else begin
            // A load in EX has no result yet; anything older than MEM has no forwarding path.
            hazard = (m1[0] || m2[0]) && ent[0].mem_read;
            for (int k = 2; k < DEPTH; k++) begin
                hazard = hazard || m1[k] || m2[k];
            end
        end
    end

    assign stall = !rst && !br_taken && hazard;
    assign flush = br_taken;
    assign issue = id_valid && !stall && !br_taken;

    always_comb begin
        sel1_nxt = 2'd0;
        sel2_nxt = 2'd0;
        if (FORWARD) begin
            if (m1[0])        sel1_nxt = 2'd1;
            else if (hit1_mem) sel1_nxt = 2'd2;
            if (m2[0])        sel2_nxt = 2'd1;
            else if (hit2_mem) sel2_nxt = 2'd2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage shifts off pre-edge values.
    // NOTE: the tracking array is small control state, so it is reset explicitly like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            fwd_sel1    <= 2'd0;
            fwd_sel2    <= 2'd0;
            stall_count <= '0;
        end else begin
            ent[0] <= issue ? entry_t'{1'b1, id_wb_en, id_mem_read, id_dest} : entry_t'('0);
            for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
            fwd_sel1 <= issue ? sel1_nxt : 2'd0;
            fwd_sel2 <= issue ? sel2_nxt : 2'd0;
            if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: one forwarding instance, one stall-only instance, one narrow-counter instance on shared inputs.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_src2_used = 1'b0, id_wb_en = 1'b0, id_mem_read = 1'b0, br_taken = 1'b0;
    logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;

    logic        f_stall, f_flush, n_stall, n_flush, s_stall, s_flush;
    logic [1:0]  f_sel1, f_sel2, n_sel1, n_sel2, s_sel1, s_sel2;
    logic [15:0] f_cnt, n_cnt;
    logic [3:0]  s_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(5), .DEPTH(2), .FORWARD(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .br_taken(br_taken), .stall(f_stall), .flush(f_flush), .fwd_sel1(f_sel1), .fwd_sel2(f_sel2),
        .stall_count(f_cnt));

    hazard_forward_unit #(.REG_ADDR_W(5), .DEPTH(2), .FORWARD(1'b0), .CNT_W(16)) u_nof (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .br_taken(br_taken), .stall(n_stall), .flush(n_flush), .fwd_sel1(n_sel1), .fwd_sel2(n_sel2),
        .stall_count(n_cnt));

    hazard_forward_unit #(.REG_ADDR_W(5), .DEPTH(2), .FORWARD(1'b0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .br_taken(br_taken), .stall(s_stall), .flush(s_flush), .fwd_sel1(s_sel1), .fwd_sel2(s_sel2),
        .stall_count(s_cnt));

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic used,
                         input logic wb, input logic mr, input logic [4:0] d);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_src2_used = used;
        id_wb_en = wb; id_mem_read = mr; id_dest = d;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        br_taken = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1);
        br_taken = 1'b1;
        #1;
        total++; if (f_flush !== 1'b1) $display("FAIL reset_flush_follows_br: got %0b want 1", f_flush); else passed++;
        total++; if (f_stall !== 1'b0 || n_stall !== 1'b0) $display("FAIL reset_stall: got %0b/%0b want 0/0", f_stall, n_stall); else passed++;
        total++; if (f_sel1 !== 2'd0 || f_sel2 !== 2'd0) $display("FAIL reset_fwd_sel: got %0d/%0d want 0/0", f_sel1, f_sel2); else passed++;
        total++; if (f_cnt !== 16'd0 || n_cnt !== 16'd0 || s_cnt !== 4'd0) $display("FAIL reset_count: got %0d/%0d/%0d want 0", f_cnt, n_cnt, s_cnt); else passed++;
        br_taken = 1'b0;
        #1;
        total++; if (f_flush !== 1'b0) $display("FAIL reset_flush_clear: got %0b want 0", f_flush); else passed++;
        idle();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(); drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3);   // add r3,r1,r2
        mid();
        total++; if (f_stall !== 1'b0) $display("FAIL b2b_producer_stall: got %0b want 0", f_stall); else passed++;
        cyc(); drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd5);   // add r5,r3,r4
        mid();
        total++; if (f_stall !== 1'b0) $display("FAIL b2b_consumer_stall: got %0b want 0", f_stall); else passed++;
        total++; if (f_sel1 !== 2'd0) $display("FAIL b2b_producer_sel1: got %0d want 0", f_sel1); else passed++;
        cyc(); idle();
        mid();
        total++; if (f_sel1 !== 2'd1) $display("FAIL b2b_consumer_sel1: got %0d want 1", f_sel1); else passed++;
        total++; if (f_sel2 !== 2'd0) $display("FAIL b2b_consumer_sel2: got %0d want 0", f_sel2); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(); drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);   // lw r4,0(r0)
        mid();
        cyc(); drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd6);   // add r6,r4,r4
        mid();
        total++; if (f_stall !== 1'b1) $display("FAIL load_use_stall_first: got %0b want 1", f_stall); else passed++;
        cyc();
        mid();
        total++; if (f_stall !== 1'b0) $display("FAIL load_use_stall_second: got %0b want 0", f_stall); else passed++;
        total++; if (f_cnt !== 16'd1) $display("FAIL load_use_count_mid: got %0d want 1", f_cnt); else passed++;
        cyc(); idle();
        mid();
        total++; if (f_sel1 !== 2'd2 || f_sel2 !== 2'd2) $display("FAIL load_use_sel: got %0d/%0d want 2/2", f_sel1, f_sel2); else passed++;
        total++; if (f_cnt !== 16'd1) $display("FAIL load_use_count_end: got %0d want 1", f_cnt); else passed++;
    endtask

    task automatic test_no_forward();
        do_reset();
        cyc(); drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3);   // add r3,r1,r2
        mid();
        cyc(); drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd7);   // sub r7,r3,r1
        mid();
        total++; if (n_stall !== 1'b1) $display("FAIL nofwd_stall_c1: got %0b want 1", n_stall); else passed++;
        cyc();
        mid();
        total++; if (n_stall !== 1'b1) $display("FAIL nofwd_stall_c2: got %0b want 1", n_stall); else passed++;
        cyc();
        mid();
        total++; if (n_stall !== 1'b0) $display("FAIL nofwd_stall_c3: got %0b want 0", n_stall); else passed++;
        cyc(); idle();
        mid();
        total++; if (n_sel1 !== 2'd0 || n_sel2 !== 2'd0) $display("FAIL nofwd_sel: got %0d/%0d want 0/0", n_sel1, n_sel2); else passed++;
        total++; if (n_cnt !== 16'd2) $display("FAIL nofwd_count: got %0d want 2", n_cnt); else passed++;
    endtask

    task automatic test_r0_and_src2();
        do_reset();
        cyc(); drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);   // writes r0
        mid();
        cyc(); drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8);   // reads r0,r0
        mid();
        total++; if (f_stall !== 1'b0 || n_stall !== 1'b0) $display("FAIL r0_stall: got %0b/%0b want 0/0", f_stall, n_stall); else passed++;
        cyc(); drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);   // producer r5
        mid();
        total++; if (f_sel1 !== 2'd0 || f_sel2 !== 2'd0) $display("FAIL r0_sel: got %0d/%0d want 0/0", f_sel1, f_sel2); else passed++;
        cyc(); drive(1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0);   // src2=r5 but not read
        mid();
        total++; if (f_stall !== 1'b0 || n_stall !== 1'b0) $display("FAIL src2_unused_stall: got %0b/%0b want 0/0", f_stall, n_stall); else passed++;
        cyc(); drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);   // src2=r5 read, producer in MEM
        mid();
        total++; if (f_sel2 !== 2'd0) $display("FAIL src2_unused_sel2: got %0d want 0", f_sel2); else passed++;
        total++; if (n_stall !== 1'b1) $display("FAIL src2_used_nofwd_stall: got %0b want 1", n_stall); else passed++;
        total++; if (f_stall !== 1'b0) $display("FAIL src2_used_fwd_stall: got %0b want 0", f_stall); else passed++;
        cyc(); idle();
        mid();
        total++; if (f_sel2 !== 2'd2) $display("FAIL src2_used_sel2: got %0d want 2", f_sel2); else passed++;
    endtask

    task automatic test_branch_over_hazard();
        do_reset();
        cyc(); drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);   // lw r4
        mid();
        cyc(); drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd6);   // add r6,r4,r4 squashed
        br_taken = 1'b1;
        mid();
        total++; if (f_stall !== 1'b0 || n_stall !== 1'b0) $display("FAIL branch_stall: got %0b/%0b want 0/0", f_stall, n_stall); else passed++;
        total++; if (f_flush !== 1'b1) $display("FAIL branch_flush: got %0b want 1", f_flush); else passed++;
        cyc(); br_taken = 1'b0;
        drive(1'b1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);          // probes r6 in EX slot
        mid();
        total++; if (f_stall !== 1'b0 || f_flush !== 1'b0) $display("FAIL branch_after: got stall=%0b flush=%0b want 0/0", f_stall, f_flush); else passed++;
        total++; if (f_cnt !== 16'd0) $display("FAIL branch_count: got %0d want 0", f_cnt); else passed++;
        cyc();                                                    // probes r6 in MEM slot
        mid();
        total++; if (f_sel1 !== 2'd0) $display("FAIL branch_probe_ex: got %0d want 0", f_sel1); else passed++;
        cyc(); idle();
        mid();
        total++; if (f_sel1 !== 2'd0) $display("FAIL branch_probe_mem: got %0d want 0", f_sel1); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            cyc(); drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1);  // add r1,r1,...
            mid();
            total++;
            if (n_stall !== ((c % 3) != 1))
                $display("FAIL midrst_pattern_c%0d: got %0b want %0b", c, n_stall, ((c % 3) != 1));
            else passed++;
        end
        total++; if (n_cnt !== 16'd5) $display("FAIL midrst_count_before: got %0d want 5", n_cnt); else passed++;
        total++; if (f_sel1 !== 2'd1) $display("FAIL midrst_sel_before: got %0d want 1", f_sel1); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if (n_stall !== 1'b0) $display("FAIL midrst_stall: got %0b want 0", n_stall); else passed++;
        total++; if (n_cnt !== 16'd0) $display("FAIL midrst_count: got %0d want 0", n_cnt); else passed++;
        total++; if (f_sel1 !== 2'd0 || f_sel2 !== 2'd0) $display("FAIL midrst_sel: got %0d/%0d want 0/0", f_sel1, f_sel2); else passed++;
        idle();
        #1 rst = 1'b0;
    endtask

    task automatic test_saturation();
        int stalls = 0;
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1);
        for (int c = 0; c < 200 && stalls < 19; c++) begin
            cyc();
            mid();
            if (s_stall === 1'b1) begin
                stalls++;
                if (stalls == 15) begin
                    total++; if (s_cnt !== 4'd14) $display("FAIL sat_count_pre: got %0d want 14", s_cnt); else passed++;
                end
            end
        end
        total++; if (stalls != 19) $display("FAIL sat_timeout: got %0d stalls want 19", stalls); else passed++;
        cyc(); idle();
        mid();
        total++; if (s_cnt !== 4'hF) $display("FAIL sat_count_hold: got %0d want 15", s_cnt); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #12;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_forward();
        test_r0_and_src2();
        test_branch_over_hazard();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard-detection and forwarding controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction between ID and register-file writeback. It stalls ID on unresolvable RAW hazards and produces registered forwarding selects for the EX operand muxes. It also squashes the ID-stage instruction on a taken branch. It replaces the fixed branch-only flush with a configurable stall/forward policy and a performance stall counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- DEPTH, 2, in-flight stages tracked after ID whose results are not yet visible in the register file (1..4; register file writes in first half-cycle, so WB is excluded)
- FORWARD, 1, 1 = forwarding enabled, 0 = stall on every RAW hazard
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_ADDR_W  first source register
- id_src2  in  REG_ADDR_W  second source register
- id_src2_used  in  1  src2 is read (R-type, store, beq/bne)
- id_wb_en  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- id_dest  in  REG_ADDR_W  ID destination register
- br_taken  in  1  branch taken, resolved in EX
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX
- flush  out  1  clear IF/ID
- fwd_sel1  out  2  EX operand-1 source: 0 register value, 1 EX/MEM ALU result, 2 MEM/WB write value
- fwd_sel2  out  2  same for operand 2
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Tracking shift register `ent[0..DEPTH-1]`. Each entry holds {valid, wb_en, mem_read, dest}. ent[0] is EX and ent[1] is MEM.
- Every cycle, ent[i+1] <= ent[i].
- ent[0] <= ID fields when id_valid & ~stall & ~br_taken. Otherwise ent[0] <= bubble (valid=0).
- Match(s, k) = ent[k].valid & ent[k].wb_en & ent[k].dest == s & s != 0. Register 0 never creates a hazard.
- A source is checked only if it is read. src1 is always checked when id_valid; src2 is checked only when id_src2_used.
- FORWARD=0: stall = id_valid & any Match over k in 0..DEPTH-1.
- FORWARD=1, stall conditions (any of the following):
  - Match(s,0) & ent[0].mem_read (load-use);
  - Match(s,k) with k >= 2.
- FORWARD=1, forward select:
  - next fwd_sel = 1 if Match(s,0) (non-load);
  - else 2 if Match(s,1);
  - else 0.
  - The youngest match wins.
- fwd_sel registers update only when an instruction issues. On stall or flush they load 0. With FORWARD=0 they are constant 0.
- flush = br_taken. When br_taken=1, stall is forced to 0; branch wins over any hazard.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.

## Timing
- stall and flush are combinational from the current entries and ID inputs, with the same-cycle response required.
- fwd_sel1/2 are registered. They are valid in the cycle the instruction is in EX, one cycle after issue.
- Load-use with FORWARD=1:
  - exactly 1 stall cycle;
  - the next cycle, the load sits in ent[1] and the consumer issues with fwd_sel=2.
- FORWARD=0 with a dependency on ent[0] stalls DEPTH cycles.
- Reset (asynchronous, immediate) clears the following to 0:
  - all entries valid=0;
  - fwd_sel1, fwd_sel2;
  - stall_count.
  - stall=0 and flush follows br_taken.
- Reset asserted mid-stall drops stall within the same cycle.
- Simultaneous br_taken and load-use hazard: stall=0, flush=1, ent[0] <= bubble, stall_count unchanged.

## Test plan
- FORWARD=1: add r3,r1,r2 then add r5,r3,r4 back-to-back -> stall never 1; fwd_sel1=1 in the consumer's EX cycle and fwd_sel2=0.
- FORWARD=1: lw r4,0(r0) then add r6,r4,r4 -> stall=1 for exactly one cycle, then fwd_sel1=fwd_sel2=2, stall_count=1.
- FORWARD=0, DEPTH=2: add r3 then sub r7,r3,r1 -> stall=1 for 2 cycles, fwd_sel=0, stall_count=2.
- Producer dest=r0 followed by consumer reading r0 -> no stall, fwd_sel=0. A consumer with id_src2_used=0 and src2 matching produces no stall.
- br_taken=1 in the same cycle as a load-use hazard -> stall=0, flush=1; the next cycle has no stall and the squashed instruction never appears in ent[1].
- Assert rst during a stall cycle with stall_count=5 -> stall, fwd_sel, and stall_count read 0 before the next clk edge. Force 2^CNT_W+3 stall cycles -> stall_count holds all-ones.
